// File: rtl/pe_operand_feeder_pkg.sv
// Shared definitions for the PE operand feeder: lane codes, FSM states and
// the diagonal skew applied to each lane's wavefront.
package pe_operand_feeder_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int NUM_LANES     = 3;

    localparam logic [1:0] LANE_A   = 2'd0;
    localparam logic [1:0] LANE_B   = 2'd1;
    localparam logic [1:0] LANE_C   = 2'd2;
    localparam logic [1:0] LANE_INV = 2'd3;

    localparam int SKEW_A = 0;
    localparam int SKEW_B = 1;
    localparam int SKEW_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int lane_skew(input int lane);
        case (lane)
            0:       return SKEW_A;
            1:       return SKEW_B;
            default: return SKEW_C;
        endcase
    endfunction

endpackage

// File: rtl/pe_operand_feeder_bank.sv
// One lane's operand store: DEPTH x WIDTH register file, synchronous write,
// combinational read so the top can register the selected element directly.
module operand_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_operand_feeder.sv
// Buffers lanes A/B/C and streams them into the PE as a zero-padded,
// diagonally skewed wavefront, with load/stall/done handshakes.
module pe_operand_feeder
    import pe_operand_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_lane,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             stall,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic             pe_enable,
    output logic             busy,
    output logic             done,
    output logic             lane_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + 3);

    state_t           state_reg;
    logic [TW-1:0]    t_reg;
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic             pe_enable_reg, busy_reg, done_reg, lane_err_reg, wr_ready_reg;

    logic                              wr_fire;
    logic [TW-1:0]                     step_sel;
    logic [NUM_LANES-1:0]              lane_full;
    logic [NUM_LANES-1:0][WIDTH-1:0]   lane_data;

    assign wr_fire = wr_valid && wr_ready_reg;

    // Step whose data gets registered at this edge: 0 when launching from IDLE.
    assign step_sel = (state_reg == ST_STREAM) ? t_reg + TW'(1) : '0;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam int SKEW = lane_skew(gi);

        logic [AW-1:0]    ptr_reg;
        logic [CW-1:0]    cnt_reg;
        logic             we;
        logic [TW:0]      diff;
        logic             live;
        logic [WIDTH-1:0] rdata;

        assign we   = wr_fire && (wr_lane == 2'(gi));
        assign diff = {1'b0, step_sel} - (TW + 1)'(SKEW);
        assign live = !diff[TW] && (diff[TW-1:0] < TW'(DEPTH));

        assign lane_full[gi] = (cnt_reg == CW'(DEPTH));
        assign lane_data[gi] = live ? rdata : '0;

        always_ff @(posedge clk) begin
            if (reset || state_reg == ST_DONE) begin
                ptr_reg <= '0;
                cnt_reg <= '0;
            end else if (we) begin
                ptr_reg <= ptr_reg + AW'(1);
                if (cnt_reg != CW'(DEPTH)) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end

        operand_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk   (clk),
            .we    (we),
            .waddr (ptr_reg),
            .wdata (wr_data),
            .raddr (AW'(diff)),
            .rdata (rdata)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            t_reg         <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= '0;
            pe_enable_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            lane_err_reg  <= 1'b0;
            wr_ready_reg  <= 1'b1;
        end else begin
            if (wr_fire && wr_lane == LANE_INV) begin
                lane_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    // Counts seen here predate any write accepted this cycle.
                    if (start && &lane_full) begin
                        state_reg     <= ST_STREAM;
                        t_reg         <= '0;
                        a_reg         <= lane_data[0];
                        b_reg         <= lane_data[1];
                        c_reg         <= lane_data[2];
                        pe_enable_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        wr_ready_reg  <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (stall) begin
                        pe_enable_reg <= 1'b0;
                    end else if (t_reg == TW'(DEPTH + 1)) begin
                        state_reg     <= ST_DONE;
                        a_reg         <= '0;
                        b_reg         <= '0;
                        c_reg         <= '0;
                        pe_enable_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        t_reg         <= step_sel;
                        a_reg         <= lane_data[0];
                        b_reg         <= lane_data[1];
                        c_reg         <= lane_data[2];
                        pe_enable_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    t_reg        <= '0;
                    done_reg     <= 1'b0;
                    wr_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    wr_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign c_out     = c_reg;
    assign pe_enable = pe_enable_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign lane_err  = lane_err_reg;
    assign wr_ready  = wr_ready_reg;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder: stimulus pushes expected wavefront
// steps, a negedge monitor pops and compares whenever pe_enable is high.
module tb_pe_operand_feeder;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk, reset, wr_valid, wr_ready, start, stall;
    logic [1:0]   wr_lane;
    logic [W-1:0] wr_data, a_out, b_out, c_out;
    logic         pe_enable, busy, done, lane_err;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } step_t;

    step_t exp_q[$];
    step_t prev_step;

    logic [W-1:0] mdl [3][D];
    int           mptr [3];
    int           mcnt [3];
    bit           merr;

    int checks = 0;
    int errors = 0;
    int stream_no = 0;

    pe_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_lane   (wr_lane),
        .wr_data   (wr_data),
        .start     (start),
        .stall     (stall),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .pe_enable (pe_enable),
        .busy      (busy),
        .done      (done),
        .lane_err  (lane_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_full();
        return mcnt[0] == D && mcnt[1] == D && mcnt[2] == D;
    endfunction

    task automatic model_clear_counts();
        for (int l = 0; l < 3; l++) begin
            mptr[l] = 0;
            mcnt[l] = 0;
        end
    endtask

    // Wavefront as the PE should see it: lane l lags by l steps, zero outside.
    task automatic push_stream();
        step_t e;
        for (int t = 0; t <= D + 1; t++) begin
            e.a = (t < D) ? mdl[0][t] : '0;
            e.b = (t >= 1 && t <= D) ? mdl[1][t-1] : '0;
            e.c = (t >= 2) ? mdl[2][t-2] : '0;
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1 while the DUT is known to be in IDLE.
    task automatic do_write(input int lane, input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_lane  = 2'(lane);
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (lane == 3) begin
            merr = 1'b1;
        end else begin
            mdl[lane][mptr[lane]] = d;
            mptr[lane] = (mptr[lane] + 1) % D;
            if (mcnt[lane] < D) mcnt[lane]++;
        end
    endtask

    task automatic load_random();
        int n = 0;
        while (n < 200 && (!model_full() || $urandom_range(0, 3) != 0)) begin
            do_write($urandom_range(0, 2), W'($urandom));
            n++;
        end
    endtask

    // mode 0: no stall, 1: stall three cycles on step 4, 2: random stall.
    task automatic run_stream(input int mode);
        int  k, nst;
        bit  ok;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ok = model_full();
        if (!ok) begin
            chk("ignored_start_busy", 32'(busy), 0);
            chk("ignored_start_wr_ready", 32'(wr_ready), 1);
            $display("stream start ignored (lanes not full)");
            return;
        end
        push_stream();
        stream_no++;
        nst = 0;
        k = 1;
        while (k <= 80) begin
            if (k == 1) begin
                chk("launch_busy", 32'(busy), 1);
                chk("launch_wr_ready", 32'(wr_ready), 0);
            end
            if (done) break;
            case (mode)
                1:       stall = (k >= 5 && k <= 7);
                2:       stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            if (stall) nst++;
            @(posedge clk);
            #1;
            k++;
        end
        stall = 1'b0;
        chk("done_latency", 32'(k), 32'(D + 3 + nst));
        chk("done_busy", 32'(busy), 0);
        model_clear_counts();
        @(posedge clk);
        #1;
        chk("post_done_wr_ready", 32'(wr_ready), 1);
        chk("post_done_pulse", 32'(done), 0);
        $display("stream %0d mode %0d stalls %0d done at N+%0d", stream_no, mode, nst, k);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (pe_enable) begin
                chk("step_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    step_t e;
                    e = exp_q.pop_front();
                    chk("a_out", 32'(a_out), 32'(e.a));
                    chk("b_out", 32'(b_out), 32'(e.b));
                    chk("c_out", 32'(c_out), 32'(e.c));
                end
            end else if (busy) begin
                chk("stall_hold", 32'({a_out, b_out, c_out}), 32'(prev_step));
            end
            prev_step = {a_out, b_out, c_out};
        end
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_lane = '0; wr_data = '0;
        start = 1'b0; stall = 1'b0; merr = 1'b0;
        model_clear_counts();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_a", 32'(a_out), 0);
        chk("rst_b", 32'(b_out), 0);
        chk("rst_c", 32'(c_out), 0);
        chk("rst_pe_enable", 32'(pe_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lane_err", 32'(lane_err), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);

        // Reference ramp: A=1..8, B=8..1, C=2,4..16.
        for (int i = 0; i < D; i++) begin
            do_write(0, W'(i + 1));
            do_write(1, W'(D - i));
            do_write(2, W'(2 * (i + 1)));
        end
        run_stream(0);

        // Lane C one short: start ignored, then one more write completes it.
        for (int i = 0; i < D; i++) begin
            do_write(0, W'($urandom));
            do_write(1, W'($urandom));
            if (i < D - 1) do_write(2, W'($urandom));
        end
        run_stream(0);
        do_write(2, W'($urandom));
        run_stream(0);

        // Ten writes to A wrap onto A[0], A[1].
        for (int i = 0; i < D + 2; i++) do_write(0, W'(8'h30 + i));
        for (int i = 0; i < D; i++) begin
            do_write(1, W'($urandom));
            do_write(2, W'($urandom));
        end
        run_stream(0);

        // Three-cycle stall on step 4.
        load_random();
        run_stream(1);

        // Invalid lane: sticky error across a full stream.
        do_write(3, 8'h55);
        chk("lane_err_set", 32'(lane_err), 32'(merr));
        load_random();
        run_stream(2);
        chk("lane_err_sticky", 32'(lane_err), 32'(merr));

        // Reset in the middle of a stream, at step 5.
        load_random();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_stream();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_clear_counts();
        merr = 1'b0;
        chk("midrst_outputs", 32'({a_out, b_out, c_out}), 0);
        chk("midrst_pe_enable", 32'(pe_enable), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_lane_err", 32'(lane_err), 32'(merr));
        chk("midrst_wr_ready", 32'(wr_ready), 1);
        $display("reset applied mid-stream at step 5");
        run_stream(0);

        for (int it = 0; it < 12; it++) begin
            load_random();
            run_stream(2);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_operand_feeder.md
# pe_operand_feeder

Upstream stage of the self-attention processing element. It buffers three operand vectors (lanes A, B, C) of `DEPTH` elements each. On `start` it streams them into the PE's `a`/`b`/`c` inputs one element per cycle, with diagonal skew of 0/1/2 cycles, and drives the PE `enable`. It handles loading, stall, and completion handshakes so the PE array sees clean, zero-padded operand wavefronts.

## Interface
- `WIDTH`, 8, operand bit width (matches PE `a`/`b`/`c`).
- `DEPTH`, 8, elements per lane vector; power of two, ≥2.
- `clk` in 1, single clock, rising edge.
- `reset` in 1, synchronous, active-high.
- `wr_valid` in 1, load request.
- `wr_ready` out 1, load accepted when `wr_valid && wr_ready`.
- `wr_lane` in 2, 0=A, 1=B, 2=C; 3=invalid.
- `wr_data` in `WIDTH`, element to load.
- `start` in 1, begin streaming.
- `stall` in 1, freeze streaming.
- `a_out`, `b_out`, `c_out` out `WIDTH` each, to PE `a`, `b`, `c`.
- `pe_enable` out 1, to PE `enable`.
- `busy` out 1, high in STREAM.
- `done` out 1, one-cycle completion pulse.
- `lane_err` out 1, sticky; set by a write with `wr_lane==3`.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE → STREAM when `start` is high and all three lane counts equal `DEPTH`.
- STREAM → DONE after the last stream step (t = `DEPTH`+1).
- DONE → IDLE unconditionally after one cycle.
- Loading (IDLE only; `wr_ready` = state==IDLE):
  - Each lane has a write pointer and a fill count.
  - Accepted write stores to `bank[lane][ptr]`.
  - Pointer wraps modulo `DEPTH`; later writes overwrite.
  - Fill count saturates at `DEPTH`.
- A `wr_lane==3` write is dropped, but sets `lane_err`. Only `reset` clears `lane_err`.
- `start` is ignored outside IDLE and when any count < `DEPTH`.
- `start` and a write in the same cycle: the write is taken, and `start` is judged on counts before the write.
- Stream step counter t runs 0..`DEPTH`+1:
  - `a_out` = A[t] for t<`DEPTH`, else 0.
  - `b_out` = B[t-1] for 1≤t≤`DEPTH`, else 0.
  - `c_out` = C[t-2] for t≥2, else 0.
- Stall: while `stall` is sampled high, t holds, data outputs hold, and `pe_enable`=0.
- In DONE:
  - Fill counts and pointers clear.
  - Bank contents are retained, but a reload is required before the next `start`.
- Reset (any state, including mid-stream):
  - State → IDLE.
  - Counts, pointers and t → 0.
  - All outputs → 0, except `wr_ready`, which is 1 from the first cycle after reset.
  - Bank contents are don't-care.

## Timing
- All outputs are registered.
- Reset values: `a_out`=`b_out`=`c_out`=0, `pe_enable`=0, `busy`=0, `done`=0, `lane_err`=0, `wr_ready`=1 (IDLE).
- `start` is sampled at the end of cycle N.
- Cycle N+1: `busy`=1, `pe_enable`=1, `a_out`=A[0], `b_out`=0, `c_out`=0, `wr_ready`=0.
- Cycle N+1+t carries step t.
- Without stall, the last step is in cycle N+`DEPTH`+2: `c_out`=C[`DEPTH`-1], `a_out`=`b_out`=0.
- Cycle N+`DEPTH`+3 (DONE): `done`=1, `busy`=0, `pe_enable`=0, data outputs=0, `wr_ready`=0.
- Cycle N+`DEPTH`+4: IDLE, `wr_ready`=1.
- Stall sampled high at the end of cycle m:
  - Cycle m+1 repeats the data of cycle m with `pe_enable`=0.
  - Each stalled cycle adds exactly one cycle of latency.
  - Stall sampled on the final step delays DONE by the same count.
- Stall is ignored outside STREAM.

## Structure
- Shared package holds:
  - Default `WIDTH`.
  - Lane encodings `LANE_A`/`LANE_B`/`LANE_C`.
  - FSM state encoding.
  - Skew offsets 0/1/2.
- Sub-module `operand_bank`: `DEPTH`×`WIDTH` register file with one synchronous write port and one combinational read port, instantiated three times.
- FSM, counters and output registers live in the top module.

## Test plan
- Load A=1..8, B=8..1, C=2,4,..16, then `start` → cycles N+1..N+10 show `a_out`: 1..8,0,0; `b_out`: 0,8..1,0; `c_out`: 0,0,2..16. `done` is high in N+11.
- `start` with lane C holding only 7 writes → ignored: `busy` stays 0 and `wr_ready` stays 1. One more C write, then `start` → streams.
- 10 writes to lane A → A[0]=9th value, A[1]=10th value; count stays saturated at 8.
- `stall` high for 3 cycles at step t=4 → the t=4 data repeats 3 extra cycles with `pe_enable`=0, and `done` moves from N+11 to N+14.
- Write with `wr_lane=3` → `lane_err`=1 and stays 1 through a full stream. `reset` → 0.
- `reset` asserted at step t=5 → next cycle all outputs are 0, `wr_ready`=1, counts are 0, and `start` is ignored until all lanes are reloaded.
